// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word add sequencer.
//   mwadd_state_e : FSM state encoding (IDLE / RUN / DONE)
//   mwadd_idx_w() : width of the slice index register for a given WORDS count
package mwadd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mwadd_state_e;

   // Never let the index collapse to zero bits when WORDS == 1.
   function automatic int mwadd_idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/selected_carry_adder.sv
// Carry-select adder: WIDTH bits split into ADD_WIDTH-bit blocks. Each block
// precomputes its sum for carry-in 0 and 1, and the rippling block carry
// picks one.
// Ports:
//   i_a, i_b  WIDTH-bit operands
//   i_cin     carry into bit 0
//   o_sum     WIDTH-bit sum
//   o_cout    carry out of the top bit
module selected_carry_adder #(
   parameter int WIDTH     = 16,
   parameter int ADD_WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   localparam int NB = WIDTH / ADD_WIDTH;

   logic [NB:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [ADD_WIDTH:0] w_s0;
      logic [ADD_WIDTH:0] w_s1;

      assign w_s0 = {1'b0, i_a[g*ADD_WIDTH +: ADD_WIDTH]}
                  + {1'b0, i_b[g*ADD_WIDTH +: ADD_WIDTH]};
      assign w_s1 = {1'b0, i_a[g*ADD_WIDTH +: ADD_WIDTH]}
                  + {1'b0, i_b[g*ADD_WIDTH +: ADD_WIDTH]}
                  + (ADD_WIDTH+1)'(1);

      assign o_sum[g*ADD_WIDTH +: ADD_WIDTH] = w_c[g] ? w_s1[ADD_WIDTH-1:0]
                                                      : w_s0[ADD_WIDTH-1:0];
      assign w_c[g+1] = w_c[g] ? w_s1[ADD_WIDTH] : w_s0[ADD_WIDTH];
   end

   assign o_cout = w_c[NB];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Sequential wide adder: adds two WORDS*WIDTH-bit operands one WIDTH-bit
// slice per cycle (LSB slice first) through a single selected_carry_adder,
// carrying each slice's cout into the next slice.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for operands (in_ready=1)
// RUN   | adding slice r_idx, one slice per clock
// DONE  | result presented (out_valid=1), held until out_ready
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operand handshake; a_in, b_in, cin latched on accept
//   op_sub                 (MWADD_SUB_EN only) 1 = compute a_in - b_in
//   out_valid/out_ready    result handshake
//   sum_out, cout_out      result and top carry, zero unless out_valid
// Build option: define MWADD_SUB_EN to add the op_sub subtract input.
module multiword_add_sequencer
   import mwadd_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ADD_WIDTH = 4,
   parameter int WORDS     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORDS*WIDTH-1:0] a_in,
   input  logic [WORDS*WIDTH-1:0] b_in,
   input  logic                   cin,
`ifdef MWADD_SUB_EN
   input  logic                   op_sub,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORDS*WIDTH-1:0] sum_out,
   output logic                   cout_out
);

   localparam int             IDX_W    = mwadd_idx_w(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   mwadd_state_e             r_state;
   mwadd_state_e             w_state_nxt;
   logic [IDX_W-1:0]         r_idx;
   logic [WORDS*WIDTH-1:0]   r_a;
   logic [WORDS*WIDTH-1:0]   r_b;
   logic [WORDS*WIDTH-1:0]   r_result;
   logic                     r_carry;
   logic                     r_cout;

   logic [WIDTH-1:0]         w_a_slice;
   logic [WIDTH-1:0]         w_b_slice;
   logic [WIDTH-1:0]         w_sum;
   logic                     w_cout;
   logic                     w_accept;

   assign w_a_slice = r_a[r_idx*WIDTH +: WIDTH];
   assign w_b_slice = r_b[r_idx*WIDTH +: WIDTH];

   selected_carry_adder #(
      .WIDTH     (WIDTH),
      .ADD_WIDTH (ADD_WIDTH)
   ) u_adder (
      .i_a    (w_a_slice),
      .i_b    (w_b_slice),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = !rst;
            if (in_valid) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = !rst;
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      sum_out  = out_valid ? r_result : '0;
      cout_out = out_valid & r_cout;
   end

   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_accept) begin
            r_a   <= a_in;
            r_idx <= '0;
`ifdef MWADD_SUB_EN
            // Subtract as A + ~B + 1; final carry of 1 means no borrow.
            r_b     <= op_sub ? ~b_in : b_in;
            r_carry <= op_sub ? 1'b1 : cin;
`else
            r_b     <= b_in;
            r_carry <= cin;
`endif
         end else if (r_state == ST_RUN) begin
            r_result[r_idx*WIDTH +: WIDTH] <= w_sum;
            r_carry <= w_cout;
            if (r_idx == LAST_IDX) r_cout <= w_cout;
            else                   r_idx  <= r_idx + 1'b1;
         end
      end
   end

endmodule
